// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side bus of the three-way RAM arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 10, parameter int DATA_W = 32);
  logic [2:0]        dev_mem_en;
  logic [2:0]        dev_burst_en;
  logic [2:0]        dev_mem_we;
  logic [ADDR_W-1:0] dev_addr_0, dev_addr_1, dev_addr_2;
  logic [DATA_W-1:0] dev_di_0, dev_di_1, dev_di_2;
  logic [2:0]        dev_do_ack;
  logic [DATA_W-1:0] dev_do;
  logic [2:0]        dev_grant;
  modport master (
    output dev_mem_en, dev_burst_en, dev_mem_we, dev_addr_0, dev_addr_1, dev_addr_2,
           dev_di_0, dev_di_1, dev_di_2,
    input  dev_do_ack, dev_do, dev_grant
  );
  modport slave (
    input  dev_mem_en, dev_burst_en, dev_mem_we, dev_addr_0, dev_addr_1, dev_addr_2,
           dev_di_0, dev_di_1, dev_di_2,
    output dev_do_ack, dev_do, dev_grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous RAM among three requesters
module mem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      dev,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);
  localparam int BW = $clog2(BURST_LEN);
  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;
  state_t            state, state_n;
  logic [1:0]        rr_ptr, rr_n, owner, owner_n, p1, p2, pick;
  logic              we_q, we_n, burst_q, burst_n, last;
  logic [ADDR_W-1:0] base, base_n, addr_sel, ram_addr_n;
  logic [BW-1:0]     beat, beat_n;
  logic [DATA_W-1:0] di_sel, ram_di_n;
  logic              ram_en_n, ram_we_n;
  logic [2:0]        ack_n, grant_n;
  // search order starts just after the last owner, so a waiter sees at most two others
  assign p1       = rr_ptr == 2'd2 ? 2'd0 : rr_ptr + 2'd1;
  assign p2       = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
  assign pick     = dev.dev_mem_en[p1] ? p1 : dev.dev_mem_en[p2] ? p2 : rr_ptr;
  assign addr_sel = pick == 2'd0 ? dev.dev_addr_0 : pick == 2'd1 ? dev.dev_addr_1 : dev.dev_addr_2;
  assign di_sel   = owner_n == 2'd0 ? dev.dev_di_0 : owner_n == 2'd1 ? dev.dev_di_1 : dev.dev_di_2;
  assign last     = !burst_q || beat == BW'(BURST_LEN - 1);
  assign dev.dev_do = ram_do;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      rr_ptr         <= 2'd2;
      owner          <= 2'd0;
      we_q           <= 1'b0;
      burst_q        <= 1'b0;
      base           <= '0;
      beat           <= '0;
      ram_en         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_di         <= '0;
      dev.dev_do_ack <= 3'b000;
      dev.dev_grant  <= 3'b000;
    end else begin
      state          <= state_n;
      rr_ptr         <= rr_n;
      owner          <= owner_n;
      we_q           <= we_n;
      burst_q        <= burst_n;
      base           <= base_n;
      beat           <= beat_n;
      ram_en         <= ram_en_n;
      ram_we         <= ram_we_n;
      ram_addr       <= ram_addr_n;
      ram_di         <= ram_di_n;
      dev.dev_do_ack <= ack_n;
      dev.dev_grant  <= grant_n;
    end
  end
  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    owner_n = owner;
    we_n    = we_q;
    burst_n = burst_q;
    base_n  = base;
    beat_n  = beat;
    unique case (state)
      IDLE: if (|dev.dev_mem_en) begin
        state_n = ISSUE;
        owner_n = pick;
        we_n    = dev.dev_mem_we[pick];
        burst_n = dev.dev_burst_en[pick];
        base_n  = addr_sel;
        beat_n  = '0;
      end
      ISSUE: state_n = ACK;
      ACK: if (last) begin
        state_n = IDLE;
        rr_n    = owner;
        beat_n  = '0;
      end else begin
        state_n = ISSUE;
        beat_n  = beat + BW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  // RAM and ack outputs are registered, so they are computed from the next state
  always_comb begin
    ram_en_n   = state_n == ISSUE;
    ram_we_n   = ram_en_n && we_n;
    ram_addr_n = ram_en_n ? base_n + ADDR_W'(beat_n) : ram_addr;
    ram_di_n   = ram_en_n ? di_sel : ram_di;
    ack_n      = state_n == ACK ? 3'b001 << owner_n : 3'b000;
    grant_n    = state_n != IDLE ? 3'b001 << owner_n : 3'b000;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bif();
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_di, ram_do;
  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .dev(bif.slave),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );
  logic [31:0] mem [1024];
  logic        ld = 1'b0;
  logic [9:0]  ld_a = '0;
  logic [31:0] ld_d = '0;
  always @(posedge clk) begin
    if (ld) mem[ld_a] <= ld_d;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      ram_do <= mem[ram_addr];
    end
  end
  int errors = 0;
  int checks = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    bif.dev_mem_en = 3'b000; bif.dev_burst_en = 3'b000; bif.dev_mem_we = 3'b000;
    bif.dev_addr_0 = '0; bif.dev_addr_1 = '0; bif.dev_addr_2 = '0;
    bif.dev_di_0 = '0; bif.dev_di_1 = '0; bif.dev_di_2 = '0;
  endtask
  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask
  task automatic test_reset();
    clear_inputs();
    bif.dev_mem_en = 3'b111;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bif.dev_do_ack !== 3'b000) begin errors++; $display("FAIL reset_ack c%0d: got %b want 000", c, bif.dev_do_ack); end
      checks++; if (bif.dev_grant !== 3'b000) begin errors++; $display("FAIL reset_grant c%0d: got %b want 000", c, bif.dev_grant); end
      checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en c%0d: got %b want 0", c, ram_en); end
    end
    bif.dev_mem_en = 3'b000;
    reset = 1'b1;
  endtask
  task automatic test_single_read();
    ld = 1'b1; ld_a = 10'h005; ld_d = 32'hDEADBEEF;
    tick();
    ld = 1'b0;
    do_reset();
    bif.dev_mem_en = 3'b001; bif.dev_addr_0 = 10'h005;
    tick();
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL single_ram_en: got %b want 1", ram_en); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL single_ram_we: got %b want 0", ram_we); end
    checks++; if (ram_addr !== 10'h005) begin errors++; $display("FAIL single_addr: got %h want 005", ram_addr); end
    checks++; if (bif.dev_grant !== 3'b001) begin errors++; $display("FAIL single_grant: got %b want 001", bif.dev_grant); end
    tick();
    checks++; if (bif.dev_do_ack !== 3'b001) begin errors++; $display("FAIL single_ack: got %b want 001", bif.dev_do_ack); end
    checks++; if (bif.dev_do !== 32'hDEADBEEF) begin errors++; $display("FAIL single_do: got %h want deadbeef", bif.dev_do); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL single_ram_en_ack: got %b want 0", ram_en); end
    bif.dev_mem_en = 3'b000;
    tick();
    checks++; if (bif.dev_do_ack !== 3'b000) begin errors++; $display("FAIL single_ack_end: got %b want 000", bif.dev_do_ack); end
    checks++; if (bif.dev_grant !== 3'b000) begin errors++; $display("FAIL single_grant_end: got %b want 000", bif.dev_grant); end
  endtask
  task automatic test_simultaneous();
    logic [2:0] exp_g [10];
    logic [2:0] exp_a [10];
    exp_g = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
    exp_a = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000};
    do_reset();
    bif.dev_mem_en = 3'b111;
    bif.dev_addr_0 = 10'h001; bif.dev_addr_1 = 10'h002; bif.dev_addr_2 = 10'h003;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++; if (bif.dev_grant !== exp_g[c]) begin errors++; $display("FAIL rr_grant c%0d: got %b want %b", c, bif.dev_grant, exp_g[c]); end
      checks++; if (bif.dev_do_ack !== exp_a[c]) begin errors++; $display("FAIL rr_ack c%0d: got %b want %b", c, bif.dev_do_ack, exp_a[c]); end
      bif.dev_mem_en = bif.dev_mem_en & ~bif.dev_do_ack;
    end
  endtask
  task automatic test_burst_wrap();
    logic [9:0] exp_addr [4];
    exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    do_reset();
    bif.dev_mem_en = 3'b010; bif.dev_burst_en = 3'b010; bif.dev_mem_we = 3'b010;
    bif.dev_addr_1 = 10'h3FE; bif.dev_di_1 = 32'd1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        bif.dev_addr_1 = 10'h100; bif.dev_mem_we = 3'b000; bif.dev_burst_en = 3'b000;
      end
      if (c % 2 == 1) begin
        checks++; if (ram_en !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL burst_issue c%0d: got en=%b we=%b want 1 1", c, ram_en, ram_we); end
        checks++; if (ram_addr !== exp_addr[(c-1)/2]) begin errors++; $display("FAIL burst_addr c%0d: got %h want %h", c, ram_addr, exp_addr[(c-1)/2]); end
        checks++; if (ram_di !== 32'((c-1)/2 + 1)) begin errors++; $display("FAIL burst_di c%0d: got %0d want %0d", c, ram_di, (c-1)/2 + 1); end
        checks++; if (bif.dev_do_ack !== 3'b000) begin errors++; $display("FAIL burst_noack c%0d: got %b want 000", c, bif.dev_do_ack); end
      end else begin
        checks++; if (bif.dev_do_ack !== 3'b010) begin errors++; $display("FAIL burst_ack c%0d: got %b want 010", c, bif.dev_do_ack); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL burst_ram_en c%0d: got %b want 0", c, ram_en); end
        bif.dev_di_1 = bif.dev_di_1 + 32'd1;
        if (c == 8) bif.dev_mem_en = 3'b000;
      end
    end
    tick();
    checks++; if (bif.dev_grant !== 3'b000 || ram_en !== 1'b0) begin errors++; $display("FAIL burst_end: got grant=%b en=%b want 000 0", bif.dev_grant, ram_en); end
  endtask
  task automatic test_fairness();
    logic [2:0] gseq [3];
    int         gcyc [3];
    logic [2:0] exp_g [3];
    int         exp_c [3];
    logic [2:0] prev;
    int         n;
    exp_g = '{3'b001, 3'b100, 3'b001};
    exp_c = '{1, 10, 13};
    gseq = '{3'b000, 3'b000, 3'b000};
    gcyc = '{0, 0, 0};
    n = 0;
    prev = 3'b000;
    do_reset();
    bif.dev_mem_en = 3'b001; bif.dev_burst_en = 3'b001; bif.dev_addr_0 = 10'h040;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bif.dev_grant != 3'b000 && bif.dev_grant != prev && n < 3) begin
        gseq[n] = bif.dev_grant; gcyc[n] = c; n++;
      end
      prev = bif.dev_grant;
      if (c == 3) begin bif.dev_mem_en[2] = 1'b1; bif.dev_addr_2 = 10'h050; end
      if (bif.dev_do_ack[2]) bif.dev_mem_en[2] = 1'b0;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL fair_count: got %0d grants want 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (gseq[i] !== exp_g[i] || gcyc[i] != exp_c[i]) begin
        errors++; $display("FAIL fair_grant%0d: got %b at cycle %0d want %b at cycle %0d", i, gseq[i], gcyc[i], exp_g[i], exp_c[i]);
      end
    end
  endtask
  task automatic test_reset_abort();
    do_reset();
    bif.dev_mem_en = 3'b001;
    tick();
    tick();
    bif.dev_mem_en = 3'b000;
    tick();
    bif.dev_mem_en = 3'b010; bif.dev_burst_en = 3'b010; bif.dev_addr_1 = 10'h020;
    for (int c = 1; c <= 5; c++) tick();
    checks++; if (ram_en !== 1'b1 || bif.dev_grant !== 3'b010) begin errors++; $display("FAIL abort_pre: got en=%b grant=%b want 1 010", ram_en, bif.dev_grant); end
    reset = 1'b0;
    bif.dev_mem_en = 3'b000;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bif.dev_do_ack !== 3'b000) begin errors++; $display("FAIL abort_ack c%0d: got %b want 000", c, bif.dev_do_ack); end
      checks++; if (ram_en !== 1'b0 || bif.dev_grant !== 3'b000) begin errors++; $display("FAIL abort_idle c%0d: got en=%b grant=%b want 0 000", c, ram_en, bif.dev_grant); end
      tick();
    end
    clear_inputs();
    bif.dev_mem_en = 3'b111;
    tick();
    checks++; if (bif.dev_grant !== 3'b001) begin errors++; $display("FAIL abort_rr: got %b want 001", bif.dev_grant); end
    clear_inputs();
  endtask
  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_burst_wrap();
    test_fairness();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
